// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data-memory responder.
// One request in flight; performs a read/write on a 2^ADDR_W x 32-bit array
// and returns a one-cycle rsp_valid pulse with read (or echoed write) data.
// Optional macro DMEM_WAIT_EN compiles in a wait-state FSM that throttles
// the initiator through req_ready for WAIT_CYCLES cycles per access.
module data_mem_responder #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    // WAIT_CYCLES must fit the 4-bit wait counter
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("data_mem_responder: WAIT_CYCLES out of range 1..15");
    end

    logic [31:0]       mem [DEPTH];

    // Access performed on the coming edge, and the operands it uses
    logic              fire;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;

`ifdef DMEM_WAIT_EN
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    // FSM state and wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, counter and handshake; the access fires when the count expires
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        fire      = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = 4'(WAIT_CYCLES - 1);
                end
            end
            S_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    fire      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture the request on acceptance so the initiator may move on
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    assign acc_we    = lat_we;
    assign acc_addr  = lat_addr;
    assign acc_wdata = lat_wdata;
`else
    // Zero wait states: every presented request is accepted and performed at once.
    // Gating with reset keeps an edge during reset from committing a write.
    assign req_ready = 1'b1;
    assign fire      = req_valid & reset;
    assign acc_we    = req_we;
    assign acc_addr  = req_addr;
    assign acc_wdata = req_wdata;
`endif

    // Array write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (fire && acc_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    // Response pulse and held response data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            rsp_valid <= fire;
            if (fire) begin
                rsp_rdata <= acc_we ? acc_wdata : mem[acc_addr];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed + random checks of data_mem_responder
// against a transaction-level reference (pending queue + word array).
module tb_data_mem_responder;

    localparam int ADDR_W = 6;
    localparam int WC     = 2;
`ifdef DMEM_WAIT_EN
    localparam int LAT = WC;
`else
    localparam int LAT = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              req_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WC)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    typedef struct {
        int          due;
        bit          we;
        int          addr;
        logic [31:0] data;
    } pend_t;

    pend_t       pq[$];
    logic [31:0] ref_mem [1 << ADDR_W];
    bit          known   [1 << ADDR_W];
    logic [31:0] last_data;
    bit          last_known;
    int          busy_until;
    int          cyc;
    int          tests;
    int          fails;
    bit          accepted;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs at negedge against the model, note acceptance
    task automatic tick();
        bit exp_v;
        exp_v    = 1'b0;
        accepted = 1'b0;
        @(negedge clk);
        if (!reset) begin
            chk("reset_ready", 32'(req_ready), 32'd1);
            chk("reset_valid", 32'(rsp_valid), 32'd0);
            chk("reset_rdata", rsp_rdata, 32'd0);
        end else begin
            if (pq.size() > 0 && pq[0].due == cyc) begin
                pend_t p;
                p = pq.pop_front();
                exp_v = 1'b1;
                if (p.we) begin
                    ref_mem[p.addr] = p.data;
                    known[p.addr]   = 1'b1;
                    last_data       = p.data;
                    last_known      = 1'b1;
                end else begin
                    last_data  = ref_mem[p.addr];
                    last_known = known[p.addr];
                end
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
            chk("req_ready", 32'(req_ready), 32'(cyc >= busy_until));
            if (last_known) chk("rsp_rdata", rsp_rdata, last_data);
            if (req_valid && cyc >= busy_until) begin
                pq.push_back('{due: cyc + 1 + LAT, we: req_we, addr: int'(req_addr), data: req_wdata});
                busy_until = cyc + 1 + LAT;
                accepted   = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Present a request and hold it until accepted
    task automatic req(input bit we, input int addr, input logic [31:0] d);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = ADDR_W'(addr);
        req_wdata = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = accepted;
        end
        chk("accept", 32'(ok), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && pq.size() > 0; i++) tick();
        chk("drain", 32'(pq.size()), 32'd0);
    endtask

    // Asynchronous reset: outputs must clear without waiting for an edge
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(rsp_valid), 32'd0);
        chk("async_ready", 32'(req_ready), 32'd1);
        pq.delete();
        busy_until = 0;
        last_data  = 32'd0;
        last_known = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        idle(1);
    endtask

    initial begin
        bit hit;
        cyc        = 0;
        tests      = 0;
        fails      = 0;
        busy_until = 0;
        last_data  = 32'd0;
        last_known = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            known[i]   = 1'b0;
            ref_mem[i] = 32'd0;
        end

        // Reset then idle
        repeat (3) tick();
        reset = 1'b1;
        idle(5);

        // Write then read back
        req(1'b1, 'h05, 32'hDEADBEEF);
        req(1'b0, 'h05, 32'h0);
        drain();
        idle(2);

        // Back-to-back writes then reads
        for (int i = 0; i < 4; i++) req(1'b1, i, 32'h10 + 32'(i));
        for (int i = 0; i < 4; i++) req(1'b0, i, 32'h0);
        drain();
        idle(2);

        // Read held during a busy access
        req(1'b1, 'h3F, 32'h3F3F0001);
        drain();
        req(1'b1, 'h3F, 32'h3F3F0002);
        req(1'b0, 'h3F, 32'h0);
        drain();
        idle(3);

        // Reset during a pending write must not commit it
        req(1'b1, 'h0A, 32'h11111111);
        drain();
`ifdef DMEM_WAIT_EN
        req(1'b1, 'h0A, 32'hCAFEF00D);
        do_reset();
`endif
        req(1'b0, 'h0A, 32'h0);
        drain();
        idle(1);

        // Reset while the response pulse is high
        req(1'b0, 'h05, 32'h0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (pq.size() > 0 && pq[0].due == cyc) hit = 1'b1;
            else tick();
        end
        chk("pulse_reached", 32'(hit), 32'd1);
        do_reset();
        req(1'b0, 'h05, 32'h0);
        drain();

        // Random traffic, mostly on a few addresses to exercise read-after-write
        for (int n = 0; n < 300; n++) begin
            int a;
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
            req(1'($urandom_range(0, 1)), a, $urandom);
            idle(int'($urandom_range(0, 2)));
        end
        drain();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
